// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Source-domain end of a four-phase req/ack handshake. It accepts a word on
//   a valid/ready port, holds it on tx_data, raises req, and waits for the
//   synchronized ack to rise and then fall before it accepts the next word.
//
//   Ports
//     clk, rst        source clock, synchronous active-high reset
//     in_valid/in_ready/in_data   upstream word interface
//     req, tx_data    registered request level and held word to the far domain
//     ack_async       acknowledge from the far domain (asynchronous)
//     done            one-cycle pulse when a handshake completes
//     timeout_err     sticky: one phase lasted TIMEOUT cycles (0 disables)
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              ack_async,
  output logic              done,
  output logic              timeout_err
);

  // Keep the counter at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_s;
  logic [CNT_W-1:0]       cnt, cnt_nx;

  // ack synchronizer; only the last flop is ever looked at.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], ack_async};
  end
  assign ack_s = sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state. A timeout never forces a transition; the FSM keeps waiting.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && !ack_s) state_nx = REQ;
      REQ:     if (ack_s)              state_nx = DROP;
      DROP:    if (!ack_s)             state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state. A high ack_s in IDLE is leftover from a
  // misbehaving receiver, so hold off new words until it clears.
  always_comb begin
    in_ready = (state == IDLE) && !ack_s;
  end

  // Registered handshake outputs, updated on the transition edges only.
  always_ff @(posedge clk) begin
    if (rst) begin
      req     <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && state_nx == REQ) begin
        req     <= 1'b1;
        tx_data <= in_data;
      end
      if (state == REQ && state_nx == DROP) req  <= 1'b0;
      if (state == DROP && state_nx == IDLE) done <= 1'b1;
    end
  end

  // Phase counter: cleared on every transition, counts while waiting in
  // REQ/DROP, saturates at TIMEOUT.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state)                        cnt_nx = '0;
    else if (state != IDLE && cnt != CNT_MAX)     cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      // cnt_nx only equals CNT_MAX after counting, since a transition clears it.
      if (TIMEOUT != 0 && cnt_nx == CNT_MAX) timeout_err <= 1'b1;
    end
  end

endmodule
